// File: rtl/uart_alu_sequencer_pkg.sv
// Shared definitions for the UART/ALU sequencer: one-hot states, width defaults, ALU opcodes.
// Pure declarations; no logic, no latency, no flow control.
package uart_alu_sequencer_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    typedef enum logic [4:0] {
        WAIT_A  = 5'b00001,
        WAIT_B  = 5'b00010,
        WAIT_OP = 5'b00100,
        COMPUTE = 5'b01000,
        WAIT_TX = 5'b10000
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    function automatic logic is_busy(input state_t s);
        return (s == COMPUTE) || (s == WAIT_TX);
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_frame_timer.sv
// Inter-byte watchdog: counts while running, flags the last allowed cycle of a frame gap.
// Expire is combinational from the count; no backpressure. TIMEOUT_CYC=0 never expires.
module frame_timer #(
    parameter int NB_TMR      = 20,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    localparam logic [NB_TMR-1:0] LAST = (TIMEOUT_CYC == 0) ? '0 : NB_TMR'(TIMEOUT_CYC - 1);

    logic [NB_TMR-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt <= '0;
        end else if (i_clear || !i_run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + NB_TMR'(1);
        end
    end

    // A byte arriving on the last cycle clears the count and suppresses expiry.
    assign o_expire = (TIMEOUT_CYC != 0) && i_run && !i_clear && (cnt == LAST);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Sequencer: collects A, B, opcode bytes, drives the ALU, then requests one transmit of the result.
// Opcode at cycle N -> o_tx_start during N+2; bytes received while busy are dropped with o_overrun.
module uart_alu_sequencer
    import uart_alu_sequencer_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_OP       = NB_OP_DEF,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int NB_TMR      = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout
);

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] alu_a_d, alu_b_d, tx_data_d;
    logic [NB_OP-1:0]   alu_op_d;
    logic               tx_start_d, overrun_d, timeout_d;
    logic               timer_run, timer_expire;

    assign timer_run = (state_q == WAIT_B) || (state_q == WAIT_OP);

    frame_timer #(
        .NB_TMR      (NB_TMR),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_run    (timer_run),
        .i_clear  (i_rx_valid),
        .o_expire (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        alu_a_d    = o_alu_a;
        alu_b_d    = o_alu_b;
        alu_op_d   = o_alu_op;
        tx_data_d  = o_tx_data;
        tx_start_d = 1'b0;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (i_rx_valid) begin
                    alu_a_d = i_rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_valid) begin
                    alu_b_d = i_rx_data;
                    state_d = WAIT_OP;
                end else if (timer_expire) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_valid) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = COMPUTE;
                end else if (timer_expire) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            COMPUTE: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                overrun_d  = i_rx_valid;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                // A byte coincident with tx_done is still dropped.
                overrun_d = i_rx_valid;
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= WAIT_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state_q    <= state_d;
            o_alu_a    <= alu_a_d;
            o_alu_b    <= alu_b_d;
            o_alu_op   <= alu_op_d;
            o_tx_data  <= tx_data_d;
            o_tx_start <= tx_start_d;
            o_busy     <= is_busy(state_d);
            o_overrun  <= overrun_d;
            o_timeout  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench: vector table of full frames plus hand-written overrun, timeout and reset sequences.
module tb_uart_alu_sequencer;
    import uart_alu_sequencer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy, overrun, timeout;

    int checks = 0;
    int errors = 0;

    uart_alu_sequencer #(
        .NB_DATA     (8),
        .NB_OP       (6),
        .TIMEOUT_CYC (50),
        .NB_TMR      (20)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy),
        .o_overrun    (overrun),
        .o_timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        logic signed [7:0] sa;
        sa = alu_a;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SRA:  alu_result = 8'(sa >>> alu_b);
            OP_SRL:  alu_result = alu_a >> alu_b;
            OP_NOR:  alu_result = ~(alu_a | alu_b);
            default: alu_result = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Full frame with a transmitter answering tx_done 10 cycles after tx_start.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] res, input bit inject_busy, input bit inject_done);
        send_byte(a);
        check("alu_a", 32'(alu_a), 32'(a));
        check("busy_wait_b", 32'(busy), 32'd0);
        send_byte(b);
        check("alu_b", 32'(alu_b), 32'(b));
        send_byte(op);
        check("alu_op", 32'(alu_op), 32'(op[5:0]));
        check("busy_compute", 32'(busy), 32'd1);
        check("tx_start_early", 32'(tx_start), 32'd0);
        tick();
        check("tx_start_pulse", 32'(tx_start), 32'd1);
        check("tx_data", 32'(tx_data), 32'(res));
        for (int i = 1; i <= 10; i++) begin
            if (inject_busy && i == 3) begin
                rx_data  = 8'hAA;
                rx_valid = 1'b1;
            end
            if (i == 10) begin
                tx_done = 1'b1;
                if (inject_done) begin
                    rx_data  = 8'h55;
                    rx_valid = 1'b1;
                end
            end
            tick();
            rx_valid = 1'b0;
            tx_done  = 1'b0;
            if (i == 1) check("tx_start_width", 32'(tx_start), 32'd0);
            if (inject_busy && i == 3) begin
                check("overrun_pulse", 32'(overrun), 32'd1);
                check("busy_after_drop", 32'(busy), 32'd1);
            end
            if (inject_busy && i == 4) check("overrun_width", 32'(overrun), 32'd0);
        end
        check("busy_after_done", 32'(busy), 32'd0);
        if (inject_done) check("overrun_on_done", 32'(overrun), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_flags"}, 32'({tx_start, busy, overrun, timeout}), 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
        vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE};
        vecs[2] = '{8'hF0, 8'h3C, 8'h26, 8'hCC};
        vecs[3] = '{8'hF0, 8'h3C, 8'h24, 8'h30};
        vecs[4] = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
        vecs[5] = '{8'h0F, 8'hF0, 8'h27, 8'h00};
        vecs[6] = '{8'h80, 8'h01, 8'h03, 8'hC0};
        vecs[7] = '{8'h80, 8'h01, 8'h02, 8'h40};
        vecs[8] = '{8'h10, 8'h20, 8'hE0, 8'h30};
        vecs[9] = '{8'h7F, 8'h01, 8'h20, 8'h80};

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, 1'b0, 1'b0);
        end

        // Dropped bytes while busy, including one coincident with tx_done
        run_frame(8'h05, 8'h03, 8'h20, 8'h08, 1'b1, 1'b0);
        run_frame(8'h01, 8'h01, 8'h20, 8'h02, 1'b0, 1'b0);
        run_frame(8'h02, 8'h03, 8'h20, 8'h05, 1'b0, 1'b1);
        run_frame(8'h04, 8'h04, 8'h22, 8'h00, 1'b0, 1'b0);

        // Partial frame abort
        send_byte(8'h07);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (timeout) seen = 1'b1;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_cycle", 32'(n), 32'd50);
        check("timeout_keep_a", 32'(alu_a), 32'h07);
        check("timeout_keep_b", 32'(alu_b), 32'h04);
        check("timeout_busy", 32'(busy), 32'd0);
        tick();
        check("timeout_width", 32'(timeout), 32'd0);
        run_frame(8'h09, 8'h02, 8'h22, 8'h07, 1'b0, 1'b0);

        // Byte arriving on the expiry cycle is accepted
        send_byte(8'h11);
        seen = 1'b0;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (timeout) seen = 1'b1;
        end
        send_byte(8'h22);
        check("expiry_no_early_timeout", 32'(seen), 32'd0);
        check("expiry_no_timeout", 32'(timeout), 32'd0);
        check("expiry_alu_b", 32'(alu_b), 32'h22);
        send_byte(8'h20);
        tick();
        check("expiry_tx_start", 32'(tx_start), 32'd1);
        check("expiry_tx_data", 32'(tx_data), 32'h33);
        for (int i = 1; i <= 10; i++) begin
            tx_done = (i == 10);
            tick();
        end
        tx_done = 1'b0;
        check("expiry_done", 32'(busy), 32'd0);

        // Reset during WAIT_TX, then a late tx_done
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("rst_wait_tx");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("late_done_flags", 32'({tx_start, busy, overrun}), 32'd0);

        // Reset after byte B
        send_byte(8'h0A);
        send_byte(8'h0B);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("rst_mid");
        run_frame(8'h0C, 8'h0D, 8'h20, 8'h19, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
